// File: rtl/bldc_gate_pkg.sv
// Shared types and helpers for the BLDC gate driver with dead-time insertion.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bldc_gate_pkg;

    // Per-leg FSM state: both gates off in IDLE and DEAD.
    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        HIGH,
        LOW
    } leg_state_t;

    // What the upstream commutation logic wants the leg to do right now.
    typedef enum logic [1:0] {
        REQ_OFF,
        REQ_HIGH,
        REQ_LOW
    } leg_req_t;

    localparam int DEAD_CYCLES_DEFAULT = 50;
    localparam int CNT_W_DEFAULT       = 10;

    // A leg is off when disabled, faulted or PWM is low; otherwise the
    // bridge side selects which switch conducts.
    function automatic leg_req_t leg_request(input logic en,
                                             input logic flt,
                                             input logic pwm,
                                             input logic side);
        if (!en || flt || !pwm) begin
            return REQ_OFF;
        end
        return side ? REQ_HIGH : REQ_LOW;
    endfunction

    // State a leg lands in once its dead time has expired.
    function automatic leg_state_t req_to_state(input leg_req_t req);
        case (req)
            REQ_HIGH: return HIGH;
            REQ_LOW:  return LOW;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/gate_leg_deadtime.sv
// One half-bridge leg: FSM plus counter enforcing a dead time between gates.
// Latency: 1 cycle from IDLE or to off; dead_cycles+1 cycles for a HIGH<->LOW swap.
// Backpressure: none; req is sampled every cycle, changes during DEAD only matter on the last DEAD cycle.
//
// Ports: clk, reset (async, active-high), req (leg request), dead_cycles
// (counter load value), gate_h / gate_l (registered gate drives).
module gate_leg_deadtime
    import bldc_gate_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    // Reset load of the counter; kept as a constant so the async reset value is static.
    parameter int RESET_CNT = DEAD_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  leg_req_t         req,
    input  logic [CNT_W-1:0] dead_cycles,
    output logic             gate_h,
    output logic             gate_l
);

    leg_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt,   cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = req_to_state(req);
            end
            HIGH: begin
                if (req != REQ_HIGH) begin
                    state_nxt = DEAD;
                    cnt_nxt   = dead_cycles;
                end
            end
            LOW: begin
                if (req != REQ_LOW) begin
                    state_nxt = DEAD;
                    cnt_nxt   = dead_cycles;
                end
            end
            DEAD: begin
                cnt_nxt = cnt - CNT_W'(1);
                // <= guards against a zero count ever locking the leg in DEAD.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = req_to_state(req);
                end
            end
            default: begin
                state_nxt = DEAD;
                cnt_nxt   = dead_cycles;
            end
        endcase
    end

    // Gates are registered from the next state so they change on the same
    // edge as the state register, with no decode glitches at the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= DEAD;
            cnt    <= CNT_W'(RESET_CNT);
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gate_h <= (state_nxt == HIGH);
            gate_l <= (state_nxt == LOW);
        end
    end

endmodule

// File: rtl/bldc_gate_deadtime.sv
// Three-phase gate driver: request decode, dead-time legs, overcurrent fault latch.
// Latency: gate edges 1 cycle after request change (DEAD_CYCLES+1 for a swap); fault to gates off 4 cycles.
// Backpressure: none; inputs are sampled every cycle, a latched fault holds all gates off until cleared.
//
// Ports: clk, reset (async, active-high), enable, pwm_phase_a/b/c,
// bridge_side_a/b/c, fault_n (async, active-low), fault_clear (pulse),
// gate_ah/al/bh/bl/ch/cl, fault_latched, fault_count[7:0].
module bldc_gate_deadtime
    import bldc_gate_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pwm_phase_a,
    input  logic       pwm_phase_b,
    input  logic       pwm_phase_c,
    input  logic       bridge_side_a,
    input  logic       bridge_side_b,
    input  logic       bridge_side_c,
    input  logic       fault_n,
    input  logic       fault_clear,
    output logic       gate_ah,
    output logic       gate_al,
    output logic       gate_bh,
    output logic       gate_bl,
    output logic       gate_ch,
    output logic       gate_cl,
    output logic       fault_latched,
    output logic [7:0] fault_count
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);

    // fault_n is asynchronous; resetting to 1 means "no fault" while syncing up.
    logic [1:0] fault_sync;
    logic       fault_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_sync <= 2'b11;
        end else begin
            fault_sync <= {fault_sync[0], fault_n};
        end
    end

    assign fault_ok = fault_sync[1];

    // Set wins over clear, so a clear only takes effect once the comparator
    // has been seen high through the synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_latched <= 1'b0;
            fault_count   <= 8'd0;
        end else if (!fault_ok) begin
            fault_latched <= 1'b1;
            if (!fault_latched && fault_count != 8'hFF) begin
                fault_count <= fault_count + 8'd1;
            end
        end else if (fault_clear) begin
            fault_latched <= 1'b0;
        end
    end

    leg_req_t req_a, req_b, req_c;

    always_comb begin
        req_a = leg_request(enable, fault_latched, pwm_phase_a, bridge_side_a);
        req_b = leg_request(enable, fault_latched, pwm_phase_b, bridge_side_b);
        req_c = leg_request(enable, fault_latched, pwm_phase_c, bridge_side_c);
    end

    gate_leg_deadtime #(.CNT_W(CNT_W), .RESET_CNT(DEAD_CYCLES)) u_leg_a (
        .clk        (clk),
        .reset      (reset),
        .req        (req_a),
        .dead_cycles(DEAD_LOAD),
        .gate_h     (gate_ah),
        .gate_l     (gate_al)
    );

    gate_leg_deadtime #(.CNT_W(CNT_W), .RESET_CNT(DEAD_CYCLES)) u_leg_b (
        .clk        (clk),
        .reset      (reset),
        .req        (req_b),
        .dead_cycles(DEAD_LOAD),
        .gate_h     (gate_bh),
        .gate_l     (gate_bl)
    );

    gate_leg_deadtime #(.CNT_W(CNT_W), .RESET_CNT(DEAD_CYCLES)) u_leg_c (
        .clk        (clk),
        .reset      (reset),
        .req        (req_c),
        .dead_cycles(DEAD_LOAD),
        .gate_h     (gate_ch),
        .gate_l     (gate_cl)
    );

endmodule

// File: tb/tb_bldc_gate_deadtime.sv
// Bench for the three-phase gate driver with dead time and fault latch.
// Latency: n/a.
// Backpressure: n/a.
module tb_bldc_gate_deadtime;

    localparam int D = 50;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic       pwm_phase_a, pwm_phase_b, pwm_phase_c;
    logic       bridge_side_a, bridge_side_b, bridge_side_c;
    logic       fault_n, fault_clear;
    logic       gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
    logic       fault_latched;
    logic [7:0] fault_count;

    int checks  = 0;
    int passed  = 0;
    int overlap = 0;
    int cyc     = 0;
    int t_drop  = 0;
    int exp_q[$];

    // Gate index map: 5=ah 4=al 3=bh 2=bl 1=ch 0=cl
    logic [5:0] g;
    assign g = {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};

    bldc_gate_deadtime #(.DEAD_CYCLES(D), .CNT_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pwm_phase_a  (pwm_phase_a),
        .pwm_phase_b  (pwm_phase_b),
        .pwm_phase_c  (pwm_phase_c),
        .bridge_side_a(bridge_side_a),
        .bridge_side_b(bridge_side_b),
        .bridge_side_c(bridge_side_c),
        .fault_n      (fault_n),
        .fault_clear  (fault_clear),
        .gate_ah      (gate_ah),
        .gate_al      (gate_al),
        .gate_bh      (gate_bh),
        .gate_bl      (gate_bl),
        .gate_ch      (gate_ch),
        .gate_cl      (gate_cl),
        .fault_latched(fault_latched),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((gate_ah & gate_al) | (gate_bh & gate_bl) | (gate_ch & gate_cl)) begin
            overlap++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until gate idx reaches val; bounded at 200.
    task automatic wait_gate(input int idx, input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (g[idx] !== val && n < 200);
    endtask

    task automatic test_reset();
        int  n;
        logic al_seen;
        reset = 1'b1; enable = 1'b1;
        pwm_phase_a = 1'b1; bridge_side_a = 1'b1;
        pwm_phase_b = 1'b0; bridge_side_b = 1'b0;
        pwm_phase_c = 1'b0; bridge_side_c = 1'b0;
        fault_n = 1'b1; fault_clear = 1'b0;
        repeat (3) tick();
        checks++; if (g !== 6'b0) $display("FAIL reset_gates: got %b expected 000000", g); else passed++;
        checks++; if (fault_latched !== 1'b0) $display("FAIL reset_latched: got %b expected 0", fault_latched); else passed++;
        checks++; if (fault_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", fault_count); else passed++;
        reset = 1'b0;
        // 50 cycles of power-up dead time, gate on in cycle 51 (observed after edge 50).
        exp_q.push_back(D);
        n = 0; al_seen = 1'b0;
        while (gate_ah !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (gate_al !== 1'b0) al_seen = 1'b1;
        end
        checks++; if (n !== exp_q.pop_front()) $display("FAIL powerup_dead: gate_ah rose after %0d edges expected %0d", n, D); else passed++;
        checks++; if (al_seen !== 1'b0) $display("FAIL powerup_al: gate_al went high, expected low"); else passed++;
    endtask

    task automatic test_swap();
        int n1, n2;
        bridge_side_a = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(D + 1);
        wait_gate(5, 1'b0, n1);
        checks++; if (n1 !== exp_q.pop_front()) $display("FAIL swap_off: gate_ah fell after %0d edges expected 1", n1); else passed++;
        wait_gate(4, 1'b1, n2);
        checks++; if (n1 + n2 !== exp_q.pop_front()) $display("FAIL swap_on: gate_al rose after %0d edges expected %0d", n1 + n2, D + 1); else passed++;
    endtask

    task automatic test_dead_toggle();
        int  n;
        logic bh_seen;
        pwm_phase_b = 1'b1; bridge_side_b = 1'b1;
        exp_q.push_back(1);
        wait_gate(3, 1'b1, n);
        checks++; if (n !== exp_q.pop_front()) $display("FAIL idle_on: gate_bh rose after %0d edges expected 1", n); else passed++;
        // Leave HIGH, wiggle the request during DEAD, end on a LOW request.
        pwm_phase_b = 1'b0;
        exp_q.push_back(D + 1);
        n = 0; bh_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (gate_bh !== 1'b0 || gate_bl !== 1'b0) bh_seen = 1'b1;
            if (i == 9)  pwm_phase_b = 1'b1;
            if (i == 19) pwm_phase_b = 1'b0;
            if (i == 29) begin pwm_phase_b = 1'b1; bridge_side_b = 1'b0; end
        end
        while (gate_bl !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (gate_bh !== 1'b0) bh_seen = 1'b1;
        end
        checks++; if (n !== exp_q.pop_front()) $display("FAIL dead_norestart: gate_bl rose after %0d edges expected %0d", n, D + 1); else passed++;
        checks++; if (bh_seen !== 1'b0) $display("FAIL dead_gates: a leg-b gate was on during dead time"); else passed++;
        pwm_phase_c = 1'b1; bridge_side_c = 1'b1;
        wait_gate(1, 1'b1, n);
        checks++; if (n !== 1) $display("FAIL leg_c_on: gate_ch rose after %0d edges expected 1", n); else passed++;
    endtask

    task automatic test_fault();
        int n;
        fault_n = 1'b0;
        exp_q.push_back(4);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) fault_clear = 1'b1;
            if (i == 3) begin fault_clear = 1'b0; fault_n = 1'b1; end
            if (g === 6'b0 && n == 0) begin n = i; t_drop = cyc; end
        end
        checks++; if (n !== exp_q.pop_front()) $display("FAIL fault_drop: gates off after %0d edges expected 4", n); else passed++;
        checks++; if (fault_latched !== 1'b1) $display("FAIL fault_set: latched=%b expected 1", fault_latched); else passed++;
        checks++; if (fault_count !== 8'd1) $display("FAIL fault_count1: got %0d expected 1", fault_count); else passed++;
        repeat (10) tick();
        checks++; if (fault_latched !== 1'b1) $display("FAIL fault_sticky: latched=%b expected 1", fault_latched); else passed++;
        checks++; if (g !== 6'b0) $display("FAIL fault_gates: got %b expected 000000", g); else passed++;
        checks++; if (fault_count !== 8'd1) $display("FAIL fault_norecount: got %0d expected 1", fault_count); else passed++;
    endtask

    task automatic test_clear();
        int n;
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        checks++; if (fault_latched !== 1'b0) $display("FAIL clear: latched=%b expected 0", fault_latched); else passed++;
        wait_gate(4, 1'b1, n);
        checks++; if (cyc - t_drop < D || gate_al !== 1'b1) $display("FAIL clear_dead: gate_al=%b back after %0d off cycles expected >= %0d", gate_al, cyc - t_drop, D); else passed++;
    endtask

    task automatic test_saturation();
        int e;
        for (int i = 1; i <= 300; i++) begin
            fault_n = 1'b0;
            e = 1 + i;
            exp_q.push_back(e > 255 ? 255 : e);
            repeat (3) tick();
            fault_n = 1'b1;
            repeat (3) tick();
            fault_clear = 1'b1;
            tick();
            fault_clear = 1'b0;
            tick();
            e = exp_q.pop_front();
            checks++; if (int'(fault_count) !== e) $display("FAIL sat_count: event %0d count %0d expected %0d", i, fault_count, e); else passed++;
        end
        checks++; if (fault_latched !== 1'b0) $display("FAIL sat_clear: latched=%b expected 0", fault_latched); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        wait_gate(1, 1'b1, n);
        checks++; if (gate_ch !== 1'b1) $display("FAIL mid_running: gate_ch=%b expected 1", gate_ch); else passed++;
        enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (g !== 6'b0) $display("FAIL mid_async: gates %b expected 000000 before next edge", g); else passed++;
        checks++; if (fault_count !== 8'd0) $display("FAIL mid_count: got %0d expected 0", fault_count); else passed++;
        repeat (2) tick();
        enable = 1'b1;
        reset = 1'b0;
        exp_q.push_back(D);
        wait_gate(4, 1'b1, n);
        checks++; if (n !== exp_q.pop_front()) $display("FAIL mid_dead: gate_al rose after %0d edges expected %0d", n, D); else passed++;
        checks++; if (gate_ch !== 1'b1) $display("FAIL mid_leg_c: gate_ch=%b expected 1", gate_ch); else passed++;
    endtask

    task automatic test_invariant();
        checks++; if (overlap !== 0) $display("FAIL shoot_through: %0d overlapping cycles expected 0", overlap); else passed++;
    endtask

    initial begin
        test_reset();
        test_swap();
        test_dead_toggle();
        test_fault();
        test_clear();
        test_saturation();
        test_reset_mid();
        test_invariant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bldc_gate_deadtime.md
Name: bldc_gate_deadtime

Overview:
- Downstream stage of the BLDC velocity controller.
- Consumes the three-phase commutation outputs: pwm_phase_a/b/c and bridge_side_a/b/c.
- Drives six half-bridge gate signals, inserting a guaranteed dead time on every leg transition.
- Latches an external overcurrent fault and forces all gates off until the fault is explicitly cleared.

Parameters:
- DEAD_CYCLES, 50, minimum clk cycles with both gates of a leg off before either gate turns on (legal range 1..1023).
- CNT_W, 10, width of each per-leg dead-time counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  synchronous; 0 forces every leg toward off
- pwm_phase_a, pwm_phase_b, pwm_phase_c  in  1 each  PWM request per phase; same clock domain
- bridge_side_a, bridge_side_b, bridge_side_c  in  1 each  1 = high side conducts on PWM, 0 = low side
- fault_n  in  1  asynchronous active-low overcurrent comparator input
- fault_clear  in  1  single-cycle pulse that clears the latched fault
- gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl  out  1 each  registered gate drives
- fault_latched  out  1  sticky fault flag
- fault_count  out  8  saturating count of fault latch events

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values:
  - all gate outputs 0;
  - fault_latched 0;
  - fault_count 0;
  - every leg in DEAD with counter = DEAD_CYCLES, so power-up enforces a full dead time.
- Per-leg request, combinational:
  - req = OFF if !enable, or fault_latched, or pwm_x = 0;
  - otherwise req = HIGH if bridge_side_x = 1, LOW if bridge_side_x = 0.
- Per-leg FSM states:
  - IDLE: both gates off, dead time satisfied.
  - DEAD: both gates off, counter running.
  - HIGH: gate_xh = 1.
  - LOW: gate_xl = 1.
- Transitions:
  - IDLE: req HIGH → HIGH; req LOW → LOW; req OFF → stay.
  - HIGH: req ≠ HIGH → DEAD, counter loaded with DEAD_CYCLES.
  - LOW: req ≠ LOW → DEAD, counter loaded with DEAD_CYCLES.
  - DEAD: counter decrements each cycle. When counter = 1, next state follows the current req (HIGH, LOW or IDLE); otherwise stay in DEAD.
  - Changes to req while in DEAD do not restart the counter; only the req sampled on the final DEAD cycle matters.
- Gate outputs are registered decodes of the state:
  - latency from a req change in IDLE to the gate edge is 1 cycle;
  - turn-off from HIGH/LOW is 1 cycle after the req change;
  - turn-on after a HIGH↔LOW swap is exactly DEAD_CYCLES+1 cycles after the req change.
- Invariant: gate_xh & gate_xl = 0 on every cycle, including reset release and fault.
- Fault path:
  - fault_n passes through a 2-flop synchronizer.
  - The synchronized low sets fault_latched on the next edge and increments fault_count (saturating at 255).
  - Gates drop in the cycle after fault_latched rises, since req becomes OFF.
  - Any leg that was on enters DEAD.
- Fault clear:
  - fault_clear with synchronized fault_n = 1 clears fault_latched.
  - fault_clear while fault_n is still low is ignored.
  - Fault set has priority over clear in the same cycle.
  - After clear, legs resume only via IDLE/DEAD, so dead time is still honoured.
- No re-count: fault_count increments only on the 0→1 edge of fault_latched, not while the fault persists.
- Reset mid-operation: gates drop immediately (asynchronous), then the full power-up dead time applies.

Decomposition:
- Package bldc_gate_pkg holds:
  - leg_state_t enum {IDLE, DEAD, HIGH, LOW};
  - leg_req_t enum {REQ_OFF, REQ_HIGH, REQ_LOW};
  - DEAD_CYCLES default constant.
- Sub-module gate_leg_deadtime:
  - contains the per-leg FSM plus counter;
  - takes req and dead_cycles, outputs gate_h and gate_l;
  - instantiated three times.
- The top level holds the request decode, fault synchronizer, latch and counter.

Test Plan:
- Reset release with enable=1, pwm_a=1, bridge_side_a=1 → gate_ah stays 0 for 50 cycles, rises at cycle 51; gate_al stays 0.
- In HIGH, flip bridge_side_a to 0 → gate_ah falls 1 cycle later; gate_al rises exactly 51 cycles after the flip; gate_ah & gate_al never both 1.
- In DEAD, toggle pwm_b 1→0→1 at 10-cycle intervals → counter is not restarted; final state matches the req at expiry.
- Pull fault_n low for 3 cycles with all legs active → all gates 0 within 4 cycles; fault_latched=1; fault_count=1. A fault_clear pulsed while fault_n is low is ignored.
- Release fault_n, pulse fault_clear → fault_latched=0; gates return after ≥50 off cycles. Then 300 separate fault events → fault_count saturates at 255.
- Drive enable=0 mid-PWM, then assert reset asynchronously between clock edges → gates drop immediately on reset; after release, the 50-cycle dead time is enforced before any turn-on.
